// File: rtl/thru_wire_arbiter.sv
// Round-robin arbiter sharing one ThruWire echo channel between N requesters.
// Ports: clk, rst_n; req_valid/req_data/req_ready (requesters); wire_in/wire_out
// (ThruWire); out_valid/out_data/out_id/out_ready (registered beat); busy; err_mismatch.
module thru_wire_arbiter #(
    parameter int N = 4,
    parameter int W = 1,
    parameter int MAX_BURST = 2,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic [W-1:0]   wire_in,
    input  logic [W-1:0]   wire_out,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [IDW-1:0] out_id,
    input  logic           out_ready,
    output logic           busy,
    output logic           err_mismatch
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [IDW-1:0] owner, owner_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [IDW-1:0] gnt;
    logic           gnt_vld;
    logic           hold;
    logic           can_accept;
    logic           xfer;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] x);
        if (int'(x) >= N - 1) return '0;
        return x + IDW'(1);
    endfunction

    // Slot k positions after ptr in the rotating priority order.
    function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        if (j >= N) j = j - N;
        return IDW'(j);
    endfunction

    assign can_accept = !out_valid || out_ready;
    assign hold       = (state == LOCKED) && req_valid[owner];
    assign busy       = (state == LOCKED);
    assign xfer       = gnt_vld && can_accept;

    // Grant: the lock owner keeps the wire while it stays valid,
    // otherwise scan from ptr as if idle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        if (hold) begin
            gnt_vld = 1'b1;
            gnt     = owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!gnt_vld && req_valid[rot(ptr, k)]) begin
                    gnt_vld = 1'b1;
                    gnt     = rot(ptr, k);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        wire_in   = '0;
        if (gnt_vld) begin
            wire_in = req_data[int'(gnt)*W +: W];
            if (can_accept) req_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        if (hold) begin
            if (xfer) begin
                if (int'(cnt) + 1 >= MAX_BURST) begin
                    state_n = IDLE;
                    ptr_n   = wrap_inc(owner);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        end else begin
            // Owner dropped valid: release, then treat this cycle as idle.
            if (state == LOCKED) begin
                state_n = IDLE;
                ptr_n   = wrap_inc(owner);
            end
            if (xfer) begin
                if (MAX_BURST == 1) begin
                    ptr_n = wrap_inc(gnt);
                end else begin
                    state_n = LOCKED;
                    owner_n = gnt;
                    cnt_n   = CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_id       <= '0;
            err_mismatch <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= wire_out;
                out_id    <= gnt;
                if (wire_out != wire_in) err_mismatch <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_thru_wire_arbiter.sv
// Self-checking bench for thru_wire_arbiter (N=4, W=8, MAX_BURST=2).
// Vector table, directed corner sequences and a randomized model comparison.
module tb_thru_wire_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MB  = 2;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   wire_in;
    logic [W-1:0]   wire_out;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IDW-1:0] out_id;
    logic           out_ready = 1'b1;
    logic           busy;
    logic           err_mismatch;
    logic           fault = 1'b0;

    assign wire_out = fault ? ~wire_in : wire_in;

    always #5 clk = ~clk;

    thru_wire_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .wire_in(wire_in), .wire_out(wire_out),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready), .busy(busy), .err_mismatch(err_mismatch)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        fault     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        logic           ordy;
        logic [N-1:0]   e_rdy;
        logic [W-1:0]   e_win;
        logic           e_busy;
        logic           e_ov;
        logic [IDW-1:0] e_id;
        logic [W-1:0]   e_od;
    } vec_t;

    vec_t tbl[$];

    // Reference model: plain integers following the arbitration rules.
    bit m_locked;
    int m_owner, m_cnt, m_ptr;
    bit m_ov, m_err;
    int m_id;
    logic [W-1:0] m_od;

    function automatic int m_grant();
        if (m_locked && req_valid[m_owner]) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        m_ov = 0; m_err = 0; m_id = 0; m_od = '0;
    endtask

    task automatic m_step(input int g, input bit ca, input logic [W-1:0] din);
        bit x;
        x = (g >= 0) && ca;
        if (m_locked && !req_valid[m_owner]) begin
            m_locked = 0;
            m_ptr = (m_owner + 1) % N;
        end
        if (x) begin
            if (m_locked) begin
                m_cnt++;
                if (m_cnt == MB) begin
                    m_locked = 0;
                    m_ptr = (m_owner + 1) % N;
                end
            end else if (MB == 1) begin
                m_ptr = (g + 1) % N;
            end else begin
                m_locked = 1; m_owner = g; m_cnt = 1;
            end
            m_ov = 1;
            m_id = g;
            m_od = fault ? ~din : din;
            if (fault) m_err = 1;
        end else if (out_ready) begin
            m_ov = 0;
        end
    endtask

    initial begin
        logic [N*W-1:0] dall;
        logic [N-1:0]   acc;
        int             g;
        bit             ca;
        logic [W-1:0]   din;
        logic [N-1:0]   erdy;

        // Reset then idle.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("idle_ready", 32'(req_ready), 0);
            chk("idle_wire_in", 32'(wire_in), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_out_valid", 32'(out_valid), 0);
            tick();
        end
        // Async reset mid-beat.
        req_valid = 4'b0001;
        req_data  = 32'h000000AA;
        tick();
        req_valid = '0;
        chk("beat_in_flight", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 0);
        chk("async_rst_out_data", 32'(out_data), 0);
        tick();
        rst_n = 1'b1;

        // Vector table: contention, then backpressure, then drain.
        dall = 32'h40302010;
        tbl.push_back('{4'hF, dall, 1'b1, 4'b0001, 8'h10, 1'b0, 1'b1, 2'd0, 8'h10});
        tbl.push_back('{4'hF, dall, 1'b1, 4'b0001, 8'h10, 1'b1, 1'b1, 2'd0, 8'h10});
        tbl.push_back('{4'hF, dall, 1'b1, 4'b0010, 8'h20, 1'b0, 1'b1, 2'd1, 8'h20});
        tbl.push_back('{4'hF, dall, 1'b1, 4'b0010, 8'h20, 1'b1, 1'b1, 2'd1, 8'h20});
        tbl.push_back('{4'hF, dall, 1'b1, 4'b0100, 8'h30, 1'b0, 1'b1, 2'd2, 8'h30});
        tbl.push_back('{4'hF, dall, 1'b1, 4'b0100, 8'h30, 1'b1, 1'b1, 2'd2, 8'h30});
        tbl.push_back('{4'hF, dall, 1'b1, 4'b1000, 8'h40, 1'b0, 1'b1, 2'd3, 8'h40});
        tbl.push_back('{4'hF, dall, 1'b1, 4'b1000, 8'h40, 1'b1, 1'b1, 2'd3, 8'h40});
        tbl.push_back('{4'hF, dall, 1'b1, 4'b0001, 8'h10, 1'b0, 1'b1, 2'd0, 8'h10});
        tbl.push_back('{4'hF, dall, 1'b0, 4'b0000, 8'h10, 1'b1, 1'b1, 2'd0, 8'h10});
        tbl.push_back('{4'hF, dall, 1'b0, 4'b0000, 8'h10, 1'b1, 1'b1, 2'd0, 8'h10});
        tbl.push_back('{4'hF, dall, 1'b0, 4'b0000, 8'h10, 1'b1, 1'b1, 2'd0, 8'h10});
        tbl.push_back('{4'hF, dall, 1'b1, 4'b0001, 8'h10, 1'b1, 1'b1, 2'd0, 8'h10});
        tbl.push_back('{4'hF, dall, 1'b1, 4'b0010, 8'h20, 1'b0, 1'b1, 2'd1, 8'h20});
        tbl.push_back('{4'h0, dall, 1'b1, 4'b0000, 8'h00, 1'b1, 1'b0, 2'd1, 8'h20});
        foreach (tbl[i]) begin
            req_valid = tbl[i].v;
            req_data  = tbl[i].d;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_wire_in", i), 32'(wire_in), 32'(tbl[i].e_win));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            tick();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d_out_id", i), 32'(out_id), 32'(tbl[i].e_id));
            chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
        end

        // Single requester burst, re-granted after the lock releases.
        do_reset();
        req_valid = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            req_data = 32'(8'h11 * (b + 1)) << 8;
            #1;
            chk("burst_ready", 32'(req_ready), 32'b0010);
            chk("burst_busy", 32'(busy), (b == 1) ? 1 : 0);
            tick();
            chk("burst_out_data", 32'(out_data), 32'(8'h11 * (b + 1)));
            chk("burst_out_id", 32'(out_id), 1);
        end
        req_valid = '0;
        tick();

        // Early release: owner 2 drops valid, requester 3 takes over at once.
        do_reset();
        req_valid = 4'b0100;
        req_data  = 32'h00A20000;
        tick();
        chk("early_busy", 32'(busy), 1);
        req_valid = 4'b1000;
        req_data  = 32'hB3000000;
        #1;
        chk("early_ready", 32'(req_ready), 32'b1000);
        chk("early_wire_in", 32'(wire_in), 32'hB3);
        tick();
        chk("early_out_id", 32'(out_id), 3);
        chk("early_out_data", 32'(out_data), 32'hB3);
        chk("early_relock", 32'(busy), 1);
        req_valid = '0;
        tick();

        // Integrity fault on one transfer.
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0000005A;
        fault     = 1'b1;
        #1;
        chk("err_before", 32'(err_mismatch), 0);
        tick();
        fault     = 1'b0;
        req_valid = '0;
        chk("err_set", 32'(err_mismatch), 1);
        chk("err_data", 32'(out_data), 32'hA5);
        repeat (5) tick();
        chk("err_sticky", 32'(err_mismatch), 1);
        rst_n = 1'b0;
        #1;
        chk("err_cleared", 32'(err_mismatch), 0);
        tick();
        rst_n = 1'b1;

        // Randomized run against the reference model.
        do_reset();
        m_reset();
        acc = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 55);
                    req_data[i*W +: W] = W'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            fault = ($urandom_range(0, 399) == 0);
            #1;
            g    = m_grant();
            ca   = !m_ov || out_ready;
            erdy = '0;
            din  = '0;
            if (g >= 0) begin
                din = req_data[g*W +: W];
                if (ca) erdy[g] = 1'b1;
            end
            chk("rnd_ready", 32'(req_ready), 32'(erdy));
            chk("rnd_wire_in", 32'(wire_in), 32'(din));
            chk("rnd_busy", 32'(busy), 32'(m_locked));
            acc = req_ready & req_valid;
            m_step(g, ca, din);
            tick();
            fault = 1'b0;
            chk("rnd_out_valid", 32'(out_valid), 32'(m_ov));
            chk("rnd_out_id", 32'(out_id), 32'(m_id));
            chk("rnd_out_data", 32'(out_data), 32'(m_od));
            chk("rnd_err", 32'(err_mismatch), 32'(m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/thru_wire_arbiter.md
Name: thru_wire_arbiter

Overview:
- Shares one ThruWire channel (Impl side: in -> out, combinational echo) between N requesters.
- Round-robin grant with an optional burst lock.
- The block drives the wire's in port, samples its out port into a registered output stage, and tags each beat with its source id.
- Sits between requester cores and a single ThruWire instance; also checks that the echo integrity holds.

Parameters:
N, 4, number of requesters (N >= 1)
W, 1, data width of the wire and of each requester
MAX_BURST, 2, maximum consecutive beats granted to one owner before the grant rotates (MAX_BURST >= 1)
IDW, max(1,clog2(N)), width of the source id (derived, not overridable)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  N  per-requester beat valid
req_data  input  N*W  per-requester data; requester i occupies bits [i*W +: W]
req_ready  output  N  per-requester accept; one-hot or zero
wire_in  output  W  drives ThruWire in
wire_out  input  W  ThruWire out (echo)
out_valid  output  1  registered beat valid
out_data  output  W  registered beat data, sampled from wire_out
out_id  output  IDW  index of the requester that produced the beat
out_ready  input  1  downstream accept
busy  output  1  1 while in state LOCKED
err_mismatch  output  1  sticky flag; set when wire_out != wire_in on an accepted beat

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_id=0, err_mismatch=0, busy=0, state=IDLE, ptr=0, owner=0, cnt=0. A beat in flight at reset is discarded.
- can_accept = !out_valid || out_ready. This is a single-entry pipeline register and gives full throughput when out_ready=1.
- Grant:
  - LOCKED with req_valid[owner]=1: grant = owner.
  - Otherwise: grant = first i with req_valid[i]=1, scanning ptr, ptr+1, ... wrapping mod N.
  - No valid requester: no grant.
- req_ready[i] = (grant==i) & can_accept. req_ready does not depend on requesters other than through the grant.
- wire_in = req_data[grant] when a grant exists, else all zeros.
- Transfer: req_valid[g] & req_ready[g]. Latency 1 cycle: next edge sets out_valid=1, out_data=wire_out, out_id=g.
- Pop without a transfer (out_valid & out_ready, no new beat): out_valid -> 0. out_data/out_id hold their last values.
- Integrity check: on a transfer, if wire_out != wire_in, err_mismatch -> 1. It stays 1 until reset.
- State machine:
  - IDLE, transfer by g: if MAX_BURST==1, stay IDLE and set ptr=(g+1) mod N. Else go LOCKED with owner=g, cnt=1.
  - LOCKED, transfer by owner: cnt+1. If cnt+1==MAX_BURST, go IDLE and set ptr=(owner+1) mod N.
  - LOCKED, req_valid[owner]=0: go IDLE and set ptr=(owner+1) mod N in that cycle. A different requester may be granted in the same cycle (grant is computed as if IDLE).
  - LOCKED and stalled (can_accept=0): hold state, cnt and owner.
- Requester rule: once req_valid is asserted, valid and data are held until ready. Dropping valid while LOCKED but stalled is a protocol violation; the block simply releases the lock.
- Simultaneous requests in IDLE resolve by the rotating priority from ptr. The lowest index wins only when ptr=0.
- Wrap-around: ptr and owner arithmetic is mod N. When N=1, the block is always the same owner and rotation is a no-op.
- Stall on downstream (out_valid=1, out_ready=0): all req_ready=0, out_* stable.

Test Plan:
- Reset then idle, N=4, W=8: all req_valid=0 for 10 cycles -> out_valid=0, req_ready=0000, wire_in=0x00, busy=0. Assert rst_n=0 mid-beat -> out_valid=0 immediately, no clock edge needed.
- Single requester burst: req_valid=0010 continuously, data 0x11,0x22,0x33, out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, out_id=1, busy=1 during the first burst. The lock releases after 2 beats and requester 1 is re-granted in IDLE.
- Contention: req_valid=1111, ptr=0, MAX_BURST=2, out_ready=1 -> out_id sequence 0,0,1,1,2,2,3,3,0. No starvation.
- Early release: owner 2 sends 1 beat, then drops valid while req 3 is valid -> req 3 granted in the same cycle. The next beat has out_id=3.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> req_ready=0000, out_data/out_id stable, cnt frozen. Releasing out_ready resumes with no lost or duplicated beat.
- Integrity fault: force wire_out=~wire_in on one transfer -> err_mismatch=1 from the next cycle and stays 1 until rst_n=0.
